reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Parametrised in-order-commit reorder buffer: DEPTH entries, WB_CH write-back channels, LK_PORTS operand lookup ports.
//  Sits between ID (allocation), EX/WB units (result write-back) and register write-back / PC redirect (commit).
//  Adds valid/ready allocation, occupancy count, full/empty, mispredict flush and a commit stall input.
// PARAMETERS
//  DEPTH     8   entries, power of 2, >=4
//  TAG_W     3   $clog2(DEPTH); entry tag == slot index
//  DATA_W    32  result / PC width
//  RD_W      5   destination register index width
//  WB_CH     5   write-back channels (alu, fwd, jump, branch, mem)
//  LK_PORTS  2   operand lookup ports
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               async active-high reset
//  alloc_valid  in   1               ID requests an entry
//  alloc_ready  out  1               comb: !full && !flush_now
//  alloc_rd     in   RD_W            destination reg (0 = none)
//  alloc_kind   in   2               00 COMMON, 01 JUMP, 10 BRANCH, 11 rsvd (treated as COMMON)
//  alloc_tag    out  TAG_W           tag given to the next allocation (== tail)
//  wb_valid     in   WB_CH           per-channel result strobe
//  wb_tag       in   WB_CH*TAG_W     channel i at [i*TAG_W +: TAG_W]
//  wb_val       in   WB_CH*DATA_W    result / link PC / {31'b0, taken}
//  wb_next_pc   in   WB_CH*DATA_W    redirect target (JUMP/BRANCH only)
//  lk_tag       in   LK_PORTS*TAG_W  operand tags to look up
//  lk_hit       out  LK_PORTS        comb: entry valid && ready
//  lk_val       out  LK_PORTS*DATA_W comb: entry value (0 when !lk_hit)
//  commit_stall in   1               hold commit this cycle (e.g. mem busy)
//  head         out  TAG_W           oldest entry index (to mem stage)
//  head_valid   out  1               head slot valid
//  count        out  TAG_W+1         occupancy 0..DEPTH
//  full, empty  out  1 each          count==DEPTH / count==0
//  cm_valid     out  1               registered: one entry retired
//  cm_we        out  1               register write enable (COMMON/JUMP with rd!=0)
//  cm_rd        out  RD_W            retired destination
//  cm_data      out  DATA_W          retired value
//  cm_tag       out  TAG_W           retired tag
//  redirect     out  1               registered 1-cycle pulse: flush + PC redirect
//  redirect_pc  out  DATA_W          target PC, valid with redirect
// BEHAVIOUR
//  - Reset (async): head=tail=count=0, all entry valid/ready=0, every output 0 except empty=1, alloc_ready=1.
//  - All state updates on posedge clk; lookup/alloc_ready combinational from registered state (no same-cycle wb bypass).
//  - Alloc: alloc_valid&&alloc_ready -> slot[tail] = {valid=1, ready=0, rd, kind}; tail+=1 mod DEPTH.
//  - Full blocks alloc even if a commit happens the same edge (no pass-through).
//  - Write-back: each wb_valid[i] sets ready=1 and val (next_pc for JUMP/BRANCH) of slot wb_tag[i], only if that slot is valid.
//    Writes to invalid slots are dropped. Same tag on two channels: highest index wins.
//  - Commit candidate: slot[head] valid && ready && !commit_stall; at most 1 retire/cycle.
//    Edge: cm_* registered from the slot, slot cleared, head+=1. Otherwise cm_valid=0, cm_we=0.
//    cm_we = (kind COMMON|JUMP) && rd!=0; BRANCH never writes (cm_we=0, cm_data=val).
//  - flush_now (comb) = candidate && (kind==JUMP || (kind==BRANCH && val[0])).
//    Edge: redirect=1, redirect_pc=next_pc, all slots invalidated, head=tail=old head+1, count=0. Alloc blocked that cycle.
//  - A write-back landing in the flush edge is discarded.
//  - count' = count + alloc_fire - commit_fire (0 after a flush); full/empty follow count, never from head==tail.
//  - Wrap-around: head/tail wrap modulo DEPTH; tag reuse is legal only after the slot retires.
//  - Reset mid-operation: state cleared immediately (async); in-flight cm/redirect pulses drop to 0.
// TESTING (DEPTH=8, WB_CH=5)
//  1. Reset, 8 allocs (rd=1..8), no wb -> alloc_tag 0..7, full=1, alloc_ready=0, count=8; 9th alloc refused.
//  2. Alloc tags 0,1; wb ch0 tag1 val=0x22, next cycle ch1 tag0 val=0x11 -> commits in order:
//     cm tag0 data 0x11, then tag1 data 0x22, in consecutive cycles.
//  3. BRANCH at tag2 with 3 younger entries; wb taken=1, next_pc=0x400 ->
//     redirect=1, redirect_pc=0x400, count=0, head=tail=3, cm_we=0.
//     Not-taken variant: no redirect, younger entries retire normally.
//  4. JUMP rd=31 val=0x104 next_pc=0x200 -> cm_we=1, rd=31, data=0x104, redirect_pc=0x200 same cycle.
//  5. Ch0 and ch3 both write tag4 (0xA, 0xB) same edge -> lk_val for tag4 = 0xB.
//     Write to an unallocated tag is ignored (lk_hit=0).
//  6. Full queue, commit_stall=1 for 3 cycles with head ready -> no cm_valid, count stays 8.
//     Stall released -> retire, alloc wraps to tag0. Async rst asserted mid-stream -> all outputs 0 without a clock.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Purpose: bundles the reorder buffer's allocation, write-back, lookup, status
//          and commit signals.
// Ports (slave = reorder buffer side):
//   in : alloc_valid, alloc_rd, alloc_kind, wb_valid, wb_tag, wb_val,
//        wb_next_pc, lk_tag, commit_stall
//   out: alloc_ready, alloc_tag, lk_hit, lk_val, head, head_valid, count,
//        full, empty, cm_valid, cm_we, cm_rd, cm_data, cm_tag, redirect,
//        redirect_pc
interface reorder_buffer_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_W     = 5,
  parameter int unsigned WB_CH    = 5,
  parameter int unsigned LK_PORTS = 2
);
  // allocation
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [RD_W-1:0]            alloc_rd;
  logic [1:0]                 alloc_kind;
  logic [TAG_W-1:0]           alloc_tag;
  // write-back
  logic [WB_CH-1:0]           wb_valid;
  logic [WB_CH*TAG_W-1:0]     wb_tag;
  logic [WB_CH*DATA_W-1:0]    wb_val;
  logic [WB_CH*DATA_W-1:0]    wb_next_pc;
  // operand lookup
  logic [LK_PORTS*TAG_W-1:0]  lk_tag;
  logic [LK_PORTS-1:0]        lk_hit;
  logic [LK_PORTS*DATA_W-1:0] lk_val;
  // status
  logic                       commit_stall;
  logic [TAG_W-1:0]           head;
  logic                       head_valid;
  logic [TAG_W:0]             count;
  logic                       full;
  logic                       empty;
  // commit / redirect
  logic                       cm_valid;
  logic                       cm_we;
  logic [RD_W-1:0]            cm_rd;
  logic [DATA_W-1:0]          cm_data;
  logic [TAG_W-1:0]           cm_tag;
  logic                       redirect;
  logic [DATA_W-1:0]          redirect_pc;

  modport master (
    output alloc_valid, alloc_rd, alloc_kind, wb_valid, wb_tag, wb_val,
           wb_next_pc, lk_tag, commit_stall,
    input  alloc_ready, alloc_tag, lk_hit, lk_val, head, head_valid, count,
           full, empty, cm_valid, cm_we, cm_rd, cm_data, cm_tag, redirect,
           redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_kind, wb_valid, wb_tag, wb_val,
           wb_next_pc, lk_tag, commit_stall,
    output alloc_ready, alloc_tag, lk_hit, lk_val, head, head_valid, count,
           full, empty, cm_valid, cm_we, cm_rd, cm_data, cm_tag, redirect,
           redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Purpose: in-order-commit reorder buffer. Entries are allocated at the tail
//          by ID, completed out of order by the write-back channels and
//          retired one per cycle from the head. A retiring taken branch or a
//          jump flushes every younger entry and emits a PC redirect pulse.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - asynchronous active-high reset
//   bus    - reorder_buffer_if.slave: alloc, write-back, lookup, status,
//            commit and redirect signals
module reorder_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_W     = 5,
  parameter int unsigned WB_CH    = 5,
  parameter int unsigned LK_PORTS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reorder_buffer_if.slave  bus
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;

  // entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_ready;
  logic [RD_W-1:0]   r_rd  [DEPTH];
  logic [1:0]        r_kind[DEPTH];
  logic [DATA_W-1:0] r_val [DEPTH];
  logic [DATA_W-1:0] r_npc [DEPTH];

  // pointers and occupancy
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;

  // commit / redirect registers
  logic              r_cm_valid;
  logic              r_cm_we;
  logic [RD_W-1:0]   r_cm_rd;
  logic [DATA_W-1:0] r_cm_data;
  logic [TAG_W-1:0]  r_cm_tag;
  logic              r_redirect;
  logic [DATA_W-1:0] r_redirect_pc;

  // combinational control
  logic              w_cand;
  logic              w_flush;
  logic              w_alloc_fire;
  logic              w_cm_we;
  logic [1:0]        w_head_kind;
  logic [DATA_W-1:0] w_head_val;
  logic [TAG_W-1:0]  w_head_inc;
  logic [CNT_W-1:0]  w_count_nxt;

  // per-slot merged write-back
  logic [DEPTH-1:0]  w_wb_en;
  logic [DATA_W-1:0] w_wb_val[DEPTH];
  logic [DATA_W-1:0] w_wb_npc[DEPTH];

  // lookup results
  logic [LK_PORTS-1:0]        w_lk_hit;
  logic [LK_PORTS*DATA_W-1:0] w_lk_val;

  // Retire decision for the head slot; a jump or taken branch flushes.
  always_comb begin
    w_head_kind  = r_kind[r_head];
    w_head_val   = r_val[r_head];
    w_cand       = r_valid[r_head] && r_ready[r_head] && !bus.commit_stall;
    w_flush      = w_cand && ((w_head_kind == KIND_JUMP) ||
                              ((w_head_kind == KIND_BRANCH) && w_head_val[0]));
    // Reserved kind 2'b11 behaves as COMMON, so only BRANCH suppresses the write.
    w_cm_we      = (w_head_kind != KIND_BRANCH) && (r_rd[r_head] != '0);
    // Allocation looks only at registered fullness: no pass-through on commit.
    w_alloc_fire = bus.alloc_valid && !r_full && !w_flush;
    w_head_inc   = r_head + TAG_W'(1);
  end

  // Next occupancy; full/empty are registered from it.
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_cand);
    end
  end

  // Merge write-back channels per slot; ascending scan lets the highest channel win.
  always_comb begin
    for (int unsigned s = 0; s < DEPTH; s++) begin
      w_wb_en[s]  = 1'b0;
      w_wb_val[s] = '0;
      w_wb_npc[s] = '0;
      for (int unsigned c = 0; c < WB_CH; c++) begin
        if (bus.wb_valid[c] && (bus.wb_tag[c*TAG_W +: TAG_W] == TAG_W'(s))) begin
          w_wb_en[s]  = 1'b1;
          w_wb_val[s] = bus.wb_val[c*DATA_W +: DATA_W];
          w_wb_npc[s] = bus.wb_next_pc[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Operand lookup from registered state only.
  always_comb begin
    w_lk_hit = '0;
    w_lk_val = '0;
    for (int unsigned p = 0; p < LK_PORTS; p++) begin
      if (r_valid[bus.lk_tag[p*TAG_W +: TAG_W]] && r_ready[bus.lk_tag[p*TAG_W +: TAG_W]]) begin
        w_lk_hit[p]                 = 1'b1;
        w_lk_val[p*DATA_W +: DATA_W] = r_val[bus.lk_tag[p*TAG_W +: TAG_W]];
      end
    end
  end

  // Entry storage: write-back, then retire clear, then allocation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_ready <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        r_rd[s]   <= '0;
        r_kind[s] <= '0;
        r_val[s]  <= '0;
        r_npc[s]  <= '0;
      end
    end else if (w_flush) begin
      // Same-edge write-backs are discarded along with the younger entries.
      r_valid <= '0;
      r_ready <= '0;
    end else begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (w_wb_en[s] && r_valid[s]) begin
          r_ready[s] <= 1'b1;
          r_val[s]   <= w_wb_val[s];
          r_npc[s]   <= w_wb_npc[s];
        end
      end
      if (w_cand) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_rd[r_tail]    <= bus.alloc_rd;
        r_kind[r_tail]  <= bus.alloc_kind;
      end
    end
  end

  // Head/tail pointers and occupancy; a flush restarts both past the retired slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_flush) begin
        r_head <= w_head_inc;
        r_tail <= w_head_inc;
      end else begin
        if (w_cand) begin
          r_head <= w_head_inc;
        end
        if (w_alloc_fire) begin
          r_tail <= r_tail + TAG_W'(1);
        end
      end
    end
  end

  // Registered commit and redirect pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cm_valid    <= 1'b0;
      r_cm_we       <= 1'b0;
      r_cm_rd       <= '0;
      r_cm_data     <= '0;
      r_cm_tag      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_cm_valid <= w_cand;
      r_cm_we    <= w_cand && w_cm_we;
      r_redirect <= w_flush;
      if (w_cand) begin
        r_cm_rd   <= r_rd[r_head];
        r_cm_data <= w_head_val;
        r_cm_tag  <= r_head;
      end
      if (w_flush) begin
        r_redirect_pc <= r_npc[r_head];
      end
    end
  end

  assign bus.alloc_ready = !r_full && !w_flush;
  assign bus.alloc_tag   = r_tail;
  assign bus.lk_hit      = w_lk_hit;
  assign bus.lk_val      = w_lk_val;
  assign bus.head        = r_head;
  assign bus.head_valid  = r_valid[r_head];
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.cm_valid    = r_cm_valid;
  assign bus.cm_we       = r_cm_we;
  assign bus.cm_rd       = r_cm_rd;
  assign bus.cm_data     = r_cm_data;
  assign bus.cm_tag      = r_cm_tag;
  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose: self-checking bench for reorder_buffer. A queue-based model of the
//          in-flight instructions predicts every status, lookup, commit and
//          redirect output, cycle by cycle, under directed and random stimulus.
module tb_reorder_buffer;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned WB_CH    = 5;
  localparam int unsigned LK_PORTS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .RD_W(RD_W),
                      .WB_CH(WB_CH), .LK_PORTS(LK_PORTS)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .RD_W(RD_W),
                   .WB_CH(WB_CH), .LK_PORTS(LK_PORTS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [1:0]  kind;
    bit          ready;
    logic [31:0] val;
    logic [31:0] npc;
  } ent_t;

  ent_t q[$];      // in-flight instructions, oldest first
  int   m_head;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input int tag);
    for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.alloc_valid  = 1'b0;
    bus.alloc_rd     = '0;
    bus.alloc_kind   = '0;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
    bus.wb_val       = '0;
    bus.wb_next_pc   = '0;
    bus.lk_tag       = '0;
    bus.commit_stall = 1'b0;
  endtask

  task automatic alloc(input int rd, input int kind);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'(rd);
    bus.alloc_kind  = 2'(kind);
  endtask

  task automatic set_wb(input int ch, input int tag, input logic [31:0] v, input logic [31:0] npc);
    bus.wb_valid[ch]                 = 1'b1;
    bus.wb_tag[ch*TAG_W +: TAG_W]    = 3'(tag);
    bus.wb_val[ch*DATA_W +: DATA_W]  = v;
    bus.wb_next_pc[ch*DATA_W +: DATA_W] = npc;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_count"},       bus.count, 0);
    chk({pfx, "_empty"},       bus.empty, 1);
    chk({pfx, "_full"},        bus.full, 0);
    chk({pfx, "_head"},        bus.head, 0);
    chk({pfx, "_head_valid"},  bus.head_valid, 0);
    chk({pfx, "_alloc_ready"}, bus.alloc_ready, 1);
    chk({pfx, "_alloc_tag"},   bus.alloc_tag, 0);
    chk({pfx, "_cm_valid"},    bus.cm_valid, 0);
    chk({pfx, "_cm_we"},       bus.cm_we, 0);
    chk({pfx, "_cm_data"},     bus.cm_data, 0);
    chk({pfx, "_redirect"},    bus.redirect, 0);
    chk({pfx, "_redirect_pc"}, bus.redirect_pc, 0);
    chk({pfx, "_lk_hit"},      bus.lk_hit, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_head = 0;
    #1;
    chk_reset("reset");
  endtask

  // One clock: check pre-edge outputs, advance model, check post-edge outputs.
  task automatic tick();
    int   n, tail, idx, t;
    bit   cand, flush, aready, hit;
    ent_t h, e;
    #1;
    n    = q.size();
    tail = (m_head + n) % DEPTH;
    chk("count", bus.count, 64'(n));
    chk("full", bus.full, 64'(n == DEPTH));
    chk("empty", bus.empty, 64'(n == 0));
    chk("head", bus.head, 64'(m_head));
    chk("head_valid", bus.head_valid, 64'(n > 0));
    chk("alloc_tag", bus.alloc_tag, 64'(tail));
    cand   = (n > 0) && q[0].ready && !bus.commit_stall;
    flush  = cand && ((q[0].kind == 2'b01) || ((q[0].kind == 2'b10) && q[0].val[0]));
    aready = (n < DEPTH) && !flush;
    chk("alloc_ready", bus.alloc_ready, 64'(aready));
    for (int p = 0; p < LK_PORTS; p++) begin
      t   = int'(bus.lk_tag[p*TAG_W +: TAG_W]);
      idx = find(t);
      hit = (idx >= 0) && q[idx].ready;
      chk("lk_hit", bus.lk_hit[p], 64'(hit));
      chk("lk_val", bus.lk_val[p*DATA_W +: DATA_W], hit ? 64'(q[idx].val) : 64'd0);
    end
    if (cand) h = q[0];
    for (int c = 0; c < WB_CH; c++) begin
      if (bus.wb_valid[c]) begin
        idx = find(int'(bus.wb_tag[c*TAG_W +: TAG_W]));
        if (idx >= 0) begin
          q[idx].ready = 1'b1;
          q[idx].val   = bus.wb_val[c*DATA_W +: DATA_W];
          q[idx].npc   = bus.wb_next_pc[c*DATA_W +: DATA_W];
        end
      end
    end
    if (flush) begin
      q.delete();
      m_head = (m_head + 1) % DEPTH;
    end else begin
      if (cand) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (bus.alloc_valid && aready) begin
        e.tag = tail; e.rd = bus.alloc_rd; e.kind = bus.alloc_kind;
        e.ready = 1'b0; e.val = '0; e.npc = '0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("cm_valid", bus.cm_valid, 64'(cand));
    chk("cm_we", bus.cm_we, cand ? 64'((h.kind != 2'b10) && (h.rd != 0)) : 64'd0);
    if (cand) begin
      chk("cm_rd", bus.cm_rd, 64'(h.rd));
      chk("cm_data", bus.cm_data, 64'(h.val));
      chk("cm_tag", bus.cm_tag, 64'(h.tag));
    end
    chk("redirect", bus.redirect, 64'(flush));
    if (flush) chk("redirect_pc", bus.redirect_pc, 64'(h.npc));
    chk("count_post", bus.count, 64'(q.size()));
    chk("head_post", bus.head, 64'(m_head));
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.wb_valid    = '0;
  endtask

  initial begin
    int r, ch;
    clear_inputs();

    // Fill all eight entries; the ninth request is refused.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(i + 1, 0);
      tick();
    end
    alloc(9, 0);
    tick();
    chk("t1_full", bus.full, 1);
    chk("t1_count", bus.count, 8);
    chk("t1_alloc_ready", bus.alloc_ready, 0);

    // Out-of-order completion, in-order retirement.
    do_reset();
    alloc(3, 0); tick();
    alloc(4, 0); tick();
    set_wb(0, 1, 32'h22, 0); tick();
    set_wb(1, 0, 32'h11, 0); tick();
    for (int i = 0; i < 3; i++) tick();

    // Taken branch at tag2 flushes three younger entries.
    for (int taken = 1; taken >= 0; taken--) begin
      do_reset();
      alloc(1, 0); tick();
      alloc(2, 0); tick();
      alloc(0, 2); tick();
      alloc(3, 0); tick();
      alloc(4, 0); tick();
      alloc(5, 0); tick();
      set_wb(0, 0, 32'h100, 0);
      set_wb(1, 1, 32'h101, 0);
      set_wb(3, 2, 32'(taken), 32'h400);
      set_wb(2, 3, 32'h103, 0);
      set_wb(4, 4, 32'h104, 0);
      tick();
      set_wb(0, 5, 32'h105, 0);
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("t3_head", bus.head, taken ? 3 : 6);
      chk("t3_alloc_tag", bus.alloc_tag, taken ? 3 : 6);
      chk("t3_count", bus.count, 0);
    end

    // Jump writes its link value and redirects in the same cycle.
    do_reset();
    alloc(31, 1); tick();
    set_wb(2, 0, 32'h104, 32'h200); tick();
    tick();
    chk("t4_redirect_pc", bus.redirect_pc, 32'h200);
    chk("t4_cm_data", bus.cm_data, 32'h104);
    tick();

    // Two channels on one tag; write to an unallocated tag.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc(i + 1, 0);
      tick();
    end
    set_wb(0, 4, 32'hA, 0);
    set_wb(3, 4, 32'hB, 0);
    set_wb(2, 6, 32'h77, 0);
    tick();
    bus.lk_tag = {3'd6, 3'd4};
    #1;
    chk("t5_lk_val", bus.lk_val[31:0], 32'hB);
    chk("t5_lk_unalloc", bus.lk_hit[1], 0);
    tick();
    bus.lk_tag = '0;

    // Commit stall on a full queue, wrap-around, then async reset mid-stream.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(i + 1, 0);
      tick();
    end
    set_wb(0, 0, 32'h5, 0); tick();
    bus.commit_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.commit_stall = 1'b0;
    tick();
    alloc(9, 0); tick();
    for (int i = 1; i < 6; i++) set_wb(i - 1, i, 32'(i * 16), 0);
    tick();
    tick();
    chk("t6_cm_valid_pre", bus.cm_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("t6_async");
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_head = 0;

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) do_reset();
      bus.alloc_valid = ($urandom_range(0, 99) < 60);
      bus.alloc_rd    = 5'($urandom_range(0, 31));
      r = int'($urandom_range(0, 9));
      bus.alloc_kind  = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      for (ch = 0; ch < WB_CH; ch++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ((q.size() > 0) && ($urandom_range(0, 3) != 0))
            r = q[$urandom_range(0, q.size() - 1)].tag;
          else
            r = int'($urandom_range(0, DEPTH - 1));
          set_wb(ch, r, $urandom, $urandom);
        end
      end
      bus.commit_stall = ($urandom_range(0, 4) == 0);
      bus.lk_tag       = 6'($urandom_range(0, 63));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
